bcdadd_seq: RTL and testbench



---
 rtl/bcdadd_seq.sv | 124 ++++++++++++
 tb/tb_bcdadd_seq.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcdadd_seq.sv
// Sequential BCD adder: one digit per clock on a shared digit adder,
// decimal carry rippled through a register, valid/ready on both sides.
module bcdadd_seq #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] op_a,
  input  logic [4*NDIG-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG+3:0] sum,
  output logic              err,
  output logic              busy
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [4*NDIG-1:0] a_r;
  logic [4*NDIG-1:0] b_r;
  logic [4*NDIG:0]   sum_r;
  logic [IW-1:0]     idx;
  logic              carry;
  logic              err_r;

  logic [3:0] da;
  logic [3:0] db;
  logic [4:0] r;
  logic [4:0] r6;
  logic [3:0] dig;
  logic       cnx;
  logic       bad;
  logic       last;
  logic       accept;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (idx == IW'(NDIG - 1));

  always_comb begin
    da  = a_r[4*idx +: 4];
    db  = b_r[4*idx +: 4];
    r   = {1'b0, da} + {1'b0, db} + {4'b0, carry};
    r6  = r + 5'd6;
    dig = r[3:0];
    cnx = 1'b0;
    if (r > 5'd9) begin
      dig = r6[3:0];
      cnx = 1'b1;
    end
  end

  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (op_a[4*i +: 4] > 4'd9 || op_b[4*i +: 4] > 4'd9)
        bad = 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid) state_nx = ADD;
      ADD:  if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Handshake flags are flops loaded from the next state, not state decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_nx == IDLE);
      out_valid <= (state_nx == DONE);
      busy      <= (state_nx == ADD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      idx   <= '0;
      carry <= 1'b0;
      err_r <= 1'b0;
    end else if (accept) begin
      a_r   <= op_a;
      b_r   <= op_b;
      sum_r <= '0;
      idx   <= '0;
      carry <= 1'b0;
      err_r <= bad;
    end else if (state == ADD) begin
      sum_r[4*idx +: 4] <= dig;
      carry             <= cnx;
      if (last) sum_r[4*NDIG] <= cnx;
      else      idx <= idx + 1'b1;
    end
  end

  assign sum = {3'b000, sum_r};
  assign err = err_r;

endmodule

// File: tb/tb_bcdadd_seq.sv
// Randomized self-checking bench for bcdadd_seq against a
// digit-wise decimal reference model.
module tb_bcdadd_seq;

  localparam int N = 3;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [4*N-1:0] op_a;
  logic [4*N-1:0] op_b;
  logic           out_valid;
  logic           out_ready;
  logic [4*N+3:0] sum;
  logic           err;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [4*N-1:0] acc_a[$];
  logic [4*N-1:0] acc_b[$];
  int             acc_c[$];
  logic [4*N+4:0] res_q[$];

  bcdadd_seq #(.NDIG(N)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op_a(op_a),
    .op_b(op_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum(sum),
    .err(err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (in_valid && in_ready) begin
      acc_a.push_back(op_a);
      acc_b.push_back(op_b);
      acc_c.push_back(cyc);
    end
    if (out_valid && out_ready)
      res_q.push_back({err, sum});
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4*N+3:0] ref_sum(logic [4*N-1:0] a,
                                             logic [4*N-1:0] b);
    logic [4*N+3:0] res;
    int c;
    int s;
    res = '0;
    c = 0;
    for (int i = 0; i < N; i++) begin
      s = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + c;
      if (s > 9) begin
        s = (s + 6) % 16;
        c = 1;
      end else begin
        c = 0;
      end
      res[4*i +: 4] = 4'(s);
    end
    res[4*N] = c[0];
    return res;
  endfunction

  function automatic logic ref_err(logic [4*N-1:0] a, logic [4*N-1:0] b);
    for (int i = 0; i < N; i++)
      if (a[4*i +: 4] > 9 || b[4*i +: 4] > 9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [4*N-1:0] rnd_op();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(0, 7) == 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
      else                           v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  task automatic run_op(logic [4*N-1:0] a, logic [4*N-1:0] b, int stall,
                        output logic [4*N+3:0] got_sum,
                        output logic got_err);
    int n;
    int lat;
    logic [4*N+3:0] s0;
    logic e0;
    got_sum = '0;
    got_err = 1'b0;
    @(negedge clk);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = rnd_op();
    op_b = rnd_op();
    check("busy_in_add", busy, 1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N);
    got_sum = sum;
    got_err = err;
    check("in_ready_done", in_ready, 0);
    s0 = sum;
    e0 = err;
    repeat (stall) begin
      @(negedge clk);
      check("hold_sum", sum, s0);
      check("hold_err", err, e0);
      check("hold_valid", out_valid, 1);
      check("hold_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_fall", out_valid, 0);
    check("ready_rise", in_ready, 1);
  endtask

  task automatic op_check(string tag, logic [4*N-1:0] a,
                          logic [4*N-1:0] b, int stall);
    logic [4*N+3:0] s;
    logic e;
    run_op(a, b, stall, s, e);
    check({tag, "_sum"}, s, ref_sum(a, b));
    check({tag, "_err"}, e, ref_err(a, b));
  endtask

  initial begin
    logic [4*N+3:0] s;
    logic e;
    logic [4*N-1:0] pa[3];
    logic [4*N-1:0] pb[3];
    int n;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op_a = '0;
    op_b = '0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sum", sum, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(12'h123, 12'h456, 0, s, e);
    check("basic_sum", s, 16'h0579);
    check("basic_err", e, 0);
    run_op(12'h999, 12'h001, 0, s, e);
    check("ripple_sum", s, 16'h1000);
    check("ripple_cout", s[4*N], 1);
    run_op(12'h999, 12'h999, 5, s, e);
    check("ripple2_sum", s, 16'h1998);
    run_op(12'h00A, 12'h000, 0, s, e);
    check("bad_sum", s, 16'h0010);
    check("bad_err", e, 1);
    run_op(12'h001, 12'h002, 0, s, e);
    check("clean_sum", s, 16'h0003);
    check("clean_err", e, 0);

    @(negedge clk);
    op_a = 12'h555;
    op_b = 12'h555;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sum", sum, 0);
    check("abort_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(12'h010, 12'h090, 0, s, e);
    check("post_rst_sum", s, 16'h0100);
    check("post_rst_err", e, 0);

    for (int k = 0; k < 12; k++)
      op_check("rand", rnd_op(), rnd_op(), $urandom_range(0, 3));

    @(negedge clk);
    acc_a.delete();
    acc_b.delete();
    acc_c.delete();
    res_q.delete();
    for (int k = 0; k < 3; k++) begin
      pa[k] = rnd_op();
      pb[k] = rnd_op();
    end
    out_ready = 1'b1;
    op_a = pa[0];
    op_b = pb[0];
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (acc_c.size() <= k && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (k < 2) begin
        op_a = pa[k+1];
        op_b = pb[k+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    n = 0;
    while (res_q.size() < 3 && n < 50) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    check("b2b_accepts", acc_c.size(), 3);
    check("b2b_results", res_q.size(), 3);
    if (acc_c.size() == 3 && res_q.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("b2b_op_a", acc_a[k], pa[k]);
        check("b2b_op_b", acc_b[k], pb[k]);
        check("b2b_sum", res_q[k][4*N+3:0], ref_sum(pa[k], pb[k]));
        check("b2b_err", res_q[k][4*N+4], ref_err(pa[k], pb[k]));
      end
      check("b2b_ii_0", acc_c[1] - acc_c[0], N + 2);
      check("b2b_ii_1", acc_c[2] - acc_c[1], N + 2);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
